// File: rtl/spi_flash_master.sv
// spi_flash_master
//   SPI mode-0 initiator for reading an external SPI flash. It sends a command
//   byte, optionally a 24-bit address, then clocks in len data bytes and hands
//   them out on a valid/ready byte stream.
//
// Ports
//   clk, reset_n         system clock, asynchronous active-low reset
//   cmd_strobe           one-cycle start request (ignored while a transfer runs)
//   cmd, has_addr, addr  command byte, address-phase enable, address (bits 23:0 sent)
//   len                  number of data bytes to read (0 = none)
//   busy, done           transfer in progress / one-cycle completion pulse
//   rx_data, rx_valid    received byte stream, consumed on rx_valid && rx_ready
//   rx_ready             consumer ready
//   spi_cs, spi_clk      chip select (active low), SCK (idles low)
//   spi_mosi, spi_miso   serial data out / in (miso is asynchronous to clk)
module spi_flash_master #(
  parameter int DIVISOR   = 4,
  parameter int LEN_WIDTH = 16,
  parameter int CS_HIGH   = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_strobe,
  input  logic [7:0]           cmd,
  input  logic                 has_addr,
  input  logic [31:0]          addr,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 spi_cs,
  output logic                 spi_clk,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

  // One counter serves as the in-bit phase counter and as the TAIL/GAP timer.
  localparam int CNT_MAX = (2 * DIVISOR > CS_HIGH) ? 2 * DIVISOR : CS_HIGH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]     CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]     CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]     HIGH_FIRST = CNT_W'(DIVISOR);
  localparam logic [CNT_W-1:0]     BIT_LAST   = CNT_W'(2 * DIVISOR - 1);
  localparam logic [CNT_W-1:0]     TAIL_LAST  = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0]     GAP_LAST   = CNT_W'(CS_HIGH - 1);
  localparam logic [LEN_WIDTH-1:0] LEN_ZERO   = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE    = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_TAIL = 3'd4,
    ST_GAP  = 3'd5
  } state_t;

  state_t               state_r, state_nx;
  logic [CNT_W-1:0]     cnt_r, cnt_nx;
  logic [4:0]           bit_r, bit_nx;
  logic [LEN_WIDTH-1:0] len_r, len_nx;
  logic                 has_addr_r, has_addr_nx;
  logic [31:0]          tx_sh_r, tx_sh_nx;
  logic [7:0]           rx_sh_r, rx_sh_nx;
  logic [7:0]           rx_data_r, rx_data_nx;
  logic                 rx_valid_r, rx_valid_nx;
  logic                 miso_meta_r, miso_sync_r;
  logic                 busy_r, busy_nx;
  logic                 done_r, done_nx;
  logic                 cs_r, cs_nx;
  logic                 sck_r, sck_nx;
  logic                 mosi_r, mosi_nx;
  logic                 bit_end_s;
  logic                 stall_s;
  logic                 shifting_nx_s;
  logic                 unused_addr_s;

  // Only the low 24 address bits go on the wire.
  assign unused_addr_s = ^addr[31:24];

  assign busy     = busy_r;
  assign done     = done_r;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign spi_cs   = cs_r;
  assign spi_clk  = sck_r;
  assign spi_mosi = mosi_r;

  // Last clk cycle of an SCK high phase: sample point and SCK falling boundary.
  assign bit_end_s = (cnt_r == BIT_LAST);
  // Hold the low phase while an unconsumed byte would otherwise be overrun.
  assign stall_s   = (state_r == ST_DATA) && (cnt_r < HIGH_FIRST) &&
                     rx_valid_r && !rx_ready;

  // Two-flop synchronizer for the asynchronous MISO line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miso_meta_r <= 1'b0;
      miso_sync_r <= 1'b0;
    end else begin
      miso_meta_r <= spi_miso;
      miso_sync_r <= miso_meta_r;
    end
  end

  // State, datapath and registered-output update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO;
      bit_r      <= 5'd0;
      len_r      <= LEN_ZERO;
      has_addr_r <= 1'b0;
      tx_sh_r    <= 32'd0;
      rx_sh_r    <= 8'd0;
      rx_data_r  <= 8'd0;
      rx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      cs_r       <= 1'b1;
      sck_r      <= 1'b0;
      mosi_r     <= 1'b0;
    end else begin
      state_r    <= state_nx;
      cnt_r      <= cnt_nx;
      bit_r      <= bit_nx;
      len_r      <= len_nx;
      has_addr_r <= has_addr_nx;
      tx_sh_r    <= tx_sh_nx;
      rx_sh_r    <= rx_sh_nx;
      rx_data_r  <= rx_data_nx;
      rx_valid_r <= rx_valid_nx;
      busy_r     <= busy_nx;
      done_r     <= done_nx;
      cs_r       <= cs_nx;
      sck_r      <= sck_nx;
      mosi_r     <= mosi_nx;
    end
  end

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_nx    = state_r;
    cnt_nx      = cnt_r;
    bit_nx      = bit_r;
    len_nx      = len_r;
    has_addr_nx = has_addr_r;
    tx_sh_nx    = tx_sh_r;
    rx_sh_nx    = rx_sh_r;
    rx_data_nx  = rx_data_r;
    // The handshake clears the byte regardless of state; a fresh byte wins below.
    rx_valid_nx = rx_valid_r && !rx_ready;

    case (state_r)
      ST_IDLE: begin
        if (cmd_strobe) begin
          state_nx    = ST_CMD;
          cnt_nx      = CNT_ZERO;
          bit_nx      = 5'd0;
          len_nx      = len;
          has_addr_nx = has_addr;
          tx_sh_nx    = {cmd, addr[23:0]};
        end else begin
          state_nx = ST_IDLE;
        end
      end

      ST_CMD: begin
        if (bit_end_s) begin
          tx_sh_nx = {tx_sh_r[30:0], 1'b0};
          cnt_nx   = CNT_ZERO;
          if (bit_r == 5'd7) begin
            bit_nx = 5'd0;
            if (has_addr_r) begin
              state_nx = ST_ADDR;
            end else if (len_r != LEN_ZERO) begin
              state_nx = ST_DATA;
            end else begin
              state_nx = ST_TAIL;
            end
          end else begin
            bit_nx = bit_r + 5'd1;
          end
        end else begin
          cnt_nx = cnt_r + CNT_ONE;
        end
      end

      ST_ADDR: begin
        if (bit_end_s) begin
          tx_sh_nx = {tx_sh_r[30:0], 1'b0};
          cnt_nx   = CNT_ZERO;
          if (bit_r == 5'd23) begin
            bit_nx = 5'd0;
            if (len_r != LEN_ZERO) begin
              state_nx = ST_DATA;
            end else begin
              state_nx = ST_TAIL;
            end
          end else begin
            bit_nx = bit_r + 5'd1;
          end
        end else begin
          cnt_nx = cnt_r + CNT_ONE;
        end
      end

      ST_DATA: begin
        if (stall_s) begin
          cnt_nx = cnt_r;
        end else if (bit_end_s) begin
          rx_sh_nx = {rx_sh_r[6:0], miso_sync_r};
          cnt_nx   = CNT_ZERO;
          if (bit_r == 5'd7) begin
            bit_nx      = 5'd0;
            rx_data_nx  = {rx_sh_r[6:0], miso_sync_r};
            rx_valid_nx = 1'b1;
            len_nx      = len_r - LEN_ONE;
            // The final byte does not wait for the consumer.
            if (len_r == LEN_ONE) begin
              state_nx = ST_TAIL;
            end else begin
              state_nx = ST_DATA;
            end
          end else begin
            bit_nx = bit_r + 5'd1;
          end
        end else begin
          cnt_nx = cnt_r + CNT_ONE;
        end
      end

      ST_TAIL: begin
        if (cnt_r == TAIL_LAST) begin
          state_nx = ST_GAP;
          cnt_nx   = CNT_ZERO;
        end else begin
          cnt_nx = cnt_r + CNT_ONE;
        end
      end

      ST_GAP: begin
        if (cnt_r == GAP_LAST) begin
          state_nx = ST_IDLE;
          cnt_nx   = CNT_ZERO;
        end else begin
          cnt_nx = cnt_r + CNT_ONE;
        end
      end

      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = CNT_ZERO;
      end
    endcase

    // Outputs are registered, so they are derived from the next state.
    shifting_nx_s = (state_nx == ST_CMD) || (state_nx == ST_ADDR) ||
                    (state_nx == ST_DATA);
    done_nx = (state_nx == ST_GAP) && (cnt_nx == GAP_LAST);
    busy_nx = (state_nx != ST_IDLE) && !done_nx;
    cs_nx   = !(shifting_nx_s || (state_nx == ST_TAIL));
    sck_nx  = shifting_nx_s && (cnt_nx >= HIGH_FIRST);
    mosi_nx = ((state_nx == ST_CMD) || (state_nx == ST_ADDR)) ? tx_sh_nx[31] : 1'b0;
  end

endmodule

// File: doc/spi_flash_master.md
Name: spi_flash_master

Overview:
- SPI mode-0 initiator that reads from a physical SPI flash chip.
- It is the opposite end of the spi_device/spi_flash responder. It shifts out a command byte and an optional 24-bit address, then clocks in N data bytes and presents them on a valid/ready byte stream.
- Sits beside the emulator so the host can dump the original flash into SDRAM over the same GPIO bus.

Parameters:
- DIVISOR, 4: clk cycles per SCK half-period; SCK = clk/(2*DIVISOR); legal range 2..255.
- LEN_WIDTH, 16: width of the byte-count input.
- CS_HIGH, 8: minimum clk cycles spi_cs is held high after a transaction before busy drops.

Ports:
- clk  input  1  system clock (132 MHz domain).
- reset_n  input  1  asynchronous, active-low reset.
- cmd_strobe  input  1  one-cycle request to start a transaction; ignored while busy.
- cmd  input  8  command byte (e.g. 8'h03 read, 8'h9F JEDEC ID).
- has_addr  input  1  1: send addr[23:0] after cmd; 0: no address phase.
- addr  input  32  flash address; only bits [23:0] are sent, MSB first.
- len  input  LEN_WIDTH  number of data bytes to clock in; 0 means none.
- busy  output  1  high from the cycle after an accepted cmd_strobe until done.
- done  output  1  one-cycle pulse in the cycle busy falls.
- rx_data  output  8  received byte; stable while rx_valid.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready.
- spi_cs  output  1  flash chip select, active low.
- spi_clk  output  1  SCK, idles low.
- spi_mosi  output  1  data to flash.
- spi_miso  input  1  data from flash; asynchronous to clk.

Behaviour:
- Reset (async, reset_n=0) forces the following immediately, including mid-transaction; the bit/byte counters clear and the FSM returns to IDLE:
  - spi_cs=1, spi_clk=0, spi_mosi=0
  - busy=0, done=0, rx_valid=0, rx_data=0
- States: IDLE, CMD, ADDR, DATA, TAIL, GAP.
- IDLE:
  - On cmd_strobe, latch cmd, has_addr, addr[23:0] and len.
  - Next cycle: busy=1, spi_cs=0, spi_clk=0, spi_mosi=cmd[7]; enter CMD.
- Bit timing (CMD, ADDR, DATA):
  - Each bit is a DIVISOR-cycle low phase followed by a DIVISOR-cycle high phase.
  - MOSI changes only on the cycle SCK falls (or at CS assertion for the first bit).
  - MISO passes through a 2-flop synchronizer. It is sampled on the last clk cycle of each high phase.
- Bytes are sent MSB first.
- After 8 bits in CMD:
  - If has_addr, go to ADDR (24 bits).
  - Else if len!=0, go to DATA.
  - Else go to TAIL.
- After ADDR: go to DATA if len!=0, else TAIL.
- DATA:
  - spi_mosi is held 0.
  - After the 8th sample, the byte loads into rx_data and rx_valid=1 on the next cycle; the byte counter decrements.
  - More bytes remaining: the next low phase's cycle count does not advance while rx_valid=1. SCK stays low and CS stays low (backpressure stall, unbounded).
  - Last byte: go to TAIL without waiting on rx_valid.
- rx_valid clears in the cycle after rx_valid && rx_ready. It is unaffected by TAIL/GAP/IDLE and persists past done.
- TAIL:
  - spi_clk=0 and spi_cs=0 for DIVISOR cycles.
  - Then spi_cs=1 and enter GAP.
- GAP:
  - Hold spi_cs=1 for CS_HIGH cycles.
  - Then done=1 for one cycle and busy=0 in that same cycle; return to IDLE.
  - A cmd_strobe is accepted in the cycle after done.
- cmd_strobe while busy is ignored, with no effect on latched values.
- Input changes after acceptance have no effect.
- len counter: LEN_WIDTH bits; max len 2^LEN_WIDTH-1; no wrap.
- SCK rising edges per transaction = 8 + (has_addr ? 24 : 0) + 8*len.
- Unstalled transaction length, from accept cycle to done cycle inclusive: 1 + edges*2*DIVISOR + DIVISOR + CS_HIGH.

Test Plan:
- Read, no backpressure:
  - Setup: DIVISOR=2, CS_HIGH=8, rx_ready=1, cmd=03, has_addr=1, addr=0x123456, len=2; flash model returns A5, 3C.
  - Required: MOSI bytes 03 12 34 56; exactly 48 SCK rising edges; rx_data A5 then 3C with one rx_valid each; done 1+192+2+8=203 cycles after accept.
- JEDEC ID, no address:
  - Stimulus: cmd=9F, has_addr=0, len=3; model returns EF 40 18.
  - Required: 32 rising edges; bytes EF, 40, 18 in order.
- Backpressure:
  - Stimulus: len=3, rx_ready held 0 for 50 cycles after first rx_valid.
  - Required: SCK stays low and spi_cs stays low for the whole stall; no byte lost or overwritten; total rising edges unchanged.
- Zero length:
  - Stimulus: cmd=06, has_addr=0, len=0.
  - Required: 8 edges; no rx_valid; done pulses; spi_cs high for ≥8 cycles before busy falls.
- Busy strobe:
  - Stimulus: cmd_strobe with cmd=AB issued mid-transaction.
  - Required: ignored; the original transaction completes byte-exact.
  - Then: cmd_strobe the cycle after done is accepted.
- Async reset mid-DATA:
  - Stimulus: reset_n pulled low mid-DATA.
  - Required: spi_cs=1, spi_clk=0, busy=0, rx_valid=0 without waiting for a clk edge.
  - Then: the next transaction after release is byte-exact.
